var_delay_line: RTL
===================

VAR_DELAY_LINE -- requirements
Module: var_delay_line

Interface
REQ-001: Parameter WIDTH, default 24, SHALL set the sample width in bits.
REQ-002: Parameter MAX_DEPTH, default 32, SHALL set the maximum delay in clock-enabled cycles; legal range 2..1024.
REQ-003: Parameter DW, default $clog2(MAX_DEPTH+1), SHALL set the width of the delay port; it is derived, not overridden.
REQ-004: clk  input  1  single clock; all state SHALL change on its rising edge, except for reset.
REQ-005: rst  input  1  asynchronous, active-low reset.
REQ-006: en  input  1  clock enable; 1 = accept a sample and advance the line this edge.
REQ-007: flush  input  1  synchronous clear of the line contents; priority over en.
REQ-008: delay  input  DW  requested delay D in enabled cycles.
REQ-009: in  input  WIDTH  sample data.
REQ-010: in_valid  input  1  sample valid tag, carried with the data.
REQ-011: out  output  WIDTH  registered delayed sample.
REQ-012: out_valid  output  1  registered delayed valid tag.
REQ-013: delay_err  output  1  registered; 1 while the requested delay is out of range and clamped.

Function
REQ-014: The effective delay Deff SHALL be delay, clamped to 1 when delay=0 and to MAX_DEPTH when delay>MAX_DEPTH; delay_err SHALL be 1 on the edge after any clamped value is sampled.
REQ-015: Deff SHALL be held in an internal register cur_delay, compared against the clamped delay on every edge, regardless of en.
REQ-016: An edge with en=1 and flush=0 is an accepted edge: {in_valid,in} SHALL be written into a circular buffer of MAX_DEPTH entries, and the write pointer SHALL advance modulo MAX_DEPTH.
REQ-017: A sample accepted at the k-th accepted edge SHALL be on out/out_valid after the (k+Deff-1)-th accepted edge; Deff=1 gives a one-cycle register.
REQ-018: A fill counter SHALL count accepted edges since the last clear, saturating at cur_delay.
REQ-019: While fill < cur_delay after an edge, out SHALL be 0 and out_valid SHALL be 0; stale buffer contents SHALL never reach out.
REQ-020: When en=0 and flush=0, buffer, pointers, fill, out and out_valid SHALL hold their values.
REQ-021: When flush=1, fill SHALL clear to 0, out SHALL be 0 and out_valid SHALL be 0 after the edge; the sample presented that cycle SHALL be discarded; pointers need not reset.
REQ-022: When the clamped delay differs from cur_delay, cur_delay SHALL load the new value and the line SHALL clear as for flush; the sample presented that cycle SHALL be discarded.
REQ-023: When a delay change and flush occur together, both SHALL take effect on the same edge.
REQ-024: Pointer wrap at MAX_DEPTH SHALL be seamless: no gap, duplicate or reorder at any Deff, including Deff=MAX_DEPTH.
REQ-025: Data SHALL pass unmodified; out_valid SHALL equal the in_valid stored with the emitted sample, and no valid gating SHALL be applied beyond REQ-019.

Reset
REQ-026: rst=0 SHALL immediately set out=0, out_valid=0, delay_err=0, fill=0, pointers=0 and cur_delay=MAX_DEPTH; buffer contents need not clear, because REQ-019 masks them.
REQ-027: Reset asserted mid-stream SHALL discard all in-flight samples; after release, the first sample SHALL appear only after a full cur_delay refill, per REQ-022 if the delay port differs.

Verification
REQ-028: delay=5, en=1 continuously, in=1,2,3... with in_valid=1 -> out=0/out_valid=0 for the first 4 edges; out=1 after the 5th edge, then out=2, 3... every edge.
REQ-029: delay=3, en toggling 1,0,1,0... -> out advances only on accepted edges; in each sample appears after its 3rd accepted edge, and holds on en=0 cycles.
REQ-030: Streaming at delay=4, then delay changed to 2 -> out=0/out_valid=0 for 1 edge after the change edge; the first post-change sample emerges 2 accepted edges after acceptance.
REQ-031: delay=0 -> behaves as D=1 with delay_err=1; delay=MAX_DEPTH+5 (37) -> D=32, delay_err=1; running 100 samples at D=32 -> exact order preserved across pointer wrap.
REQ-032: flush pulse, and separately rst low for 1 cycle, mid-stream at delay=6 -> out/out_valid=0 immediately (rst) or next edge (flush); the next in_valid=1 sample appears 6 accepted edges later with no stale data.

Source files
------------

// File: rtl/var_delay_line.sv
// var_delay_line: clock-enabled variable delay line over a circular buffer.
// Delay changes, flush and reset restart the fill so stale entries never reach out.
module var_delay_line #(
    parameter int WIDTH     = 24,
    parameter int MAX_DEPTH = 32,
    parameter int DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [DW-1:0]    delay,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             delay_err
);
    localparam int AW = $clog2(MAX_DEPTH);
    localparam logic [DW-1:0] MAXD = DW'(MAX_DEPTH);
    localparam logic [DW:0]   MAXW = (DW+1)'(MAX_DEPTH);
    logic [WIDTH:0]   mem_q [MAX_DEPTH];
    logic [AW-1:0]    wp_q, wp_d, wp_nxt, rd_idx;
    logic [DW-1:0]    cur_q, cur_d, fill_q, fill_d, fill_nxt, clamp;
    logic [DW:0]      rd_sum;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ov_q, ov_d, err_q, err_d;
    logic             clear, accept, full;
    logic [WIDTH:0]   rdata;
    assign clamp    = (delay == '0) ? DW'(1) : (delay > MAXD) ? MAXD : delay;
    assign err_d    = (delay == '0) || (delay > MAXD);
    assign clear    = flush || (clamp != cur_q);
    assign accept   = en && !clear;
    assign fill_nxt = (fill_q == cur_q) ? cur_q : fill_q + 1'b1;
    assign full     = (fill_nxt == cur_q);
    assign wp_nxt   = (wp_q == AW'(MAX_DEPTH - 1)) ? '0 : wp_q + 1'b1;
    // entry written cur-1 accepted edges ago, modulo the (possibly non power-of-two) depth
    assign rd_sum   = (DW+1)'(wp_q) + MAXW + (DW+1)'(1) - {1'b0, cur_q};
    assign rd_idx   = AW'((rd_sum >= MAXW) ? rd_sum - MAXW : rd_sum);
    assign rdata    = (cur_q == DW'(1)) ? {in_valid, in} : mem_q[rd_idx];
    always_comb begin
        cur_d  = clamp;
        wp_d   = accept ? wp_nxt : wp_q;
        fill_d = clear ? '0 : accept ? fill_nxt : fill_q;
        out_d  = clear ? '0 : accept ? (full ? rdata[WIDTH-1:0] : '0) : out_q;
        ov_d   = clear ? 1'b0 : accept ? (full && rdata[WIDTH]) : ov_q;
    end
    always_ff @(posedge clk) begin
        if (accept) mem_q[wp_q] <= {in_valid, in};
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q   <= '0;
            cur_q  <= MAXD;
            fill_q <= '0;
            out_q  <= '0;
            ov_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            wp_q   <= wp_d;
            cur_q  <= cur_d;
            fill_q <= fill_d;
            out_q  <= out_d;
            ov_q   <= ov_d;
            err_q  <= err_d;
        end
    end
    assign out       = out_q;
    assign out_valid = ov_q;
    assign delay_err = err_q;
endmodule
